cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpu_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Tiny 4-register accumulator CPU controller. A 5-state FSM
//                sequences FETCH / DECODE / EXEC against an external
//                combinational instruction ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   input  logic [1:0]  dbg_sel,
   output logic [7:0]  dbg_data,
   output logic [7:0]  pc,
   output logic        zflag,
   output logic        busy,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] C_OP_MOVI = 4'h1;
   localparam logic [3:0] C_OP_ADDI = 4'h2;
   localparam logic [3:0] C_OP_XORI = 4'h3;
   localparam logic [3:0] C_OP_JMP  = 4'h4;
   localparam logic [3:0] C_OP_JZ   = 4'h5;
   localparam logic [3:0] C_OP_JNZ  = 4'h6;
   localparam logic [3:0] C_OP_HLT  = 4'hF;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [7:0]  rf_q [4];
   logic [7:0]  rf_d [4];
   logic        z_q, z_d;
   // DECODE results held for the EXEC commit (not architectural state)
   logic [7:0]  alu_q, alu_d;
   logic        wr_q, wr_d;
   logic        take_q, take_d;

   logic [3:0]  opcode;
   logic [1:0]  reg_sel;
   logic [7:0]  imm;
   logic [7:0]  operand;
   logic        w_unused_ir;

   assign opcode      = ir_q[15:12];
   assign reg_sel     = ir_q[9:8];
   assign imm         = ir_q[7:0];
   assign operand     = rf_q[reg_sel];
   // IR bits [11:10] carry no meaning in this instruction set
   assign w_unused_ir = ^ir_q[11:10];

   // State and datapath registers, cleared asynchronously by rst_n
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= 8'h00;
         ir_q    <= 16'h0000;
         z_q     <= 1'b0;
         alu_q   <= 8'h00;
         wr_q    <= 1'b0;
         take_q  <= 1'b0;
         for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         alu_q   <= alu_d;
         wr_q    <= wr_d;
         take_q  <= take_d;
         for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
      end
   end

   // Next-state and datapath update for each FSM phase
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      z_d     = z_q;
      alu_d   = alu_q;
      wr_d    = wr_q;
      take_d  = take_q;
      for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];

      case (state_q)
         S_IDLE, S_HALT: begin
            // Registers and Z are deliberately kept across a restart
            if (start) begin
               pc_d    = 8'h00;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_d    = rom_data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            wr_d   = 1'b0;
            take_d = 1'b0;
            alu_d  = 8'h00;
            case (opcode)
               C_OP_MOVI: begin alu_d = imm;           wr_d = 1'b1; end
               C_OP_ADDI: begin alu_d = operand + imm; wr_d = 1'b1; end
               C_OP_XORI: begin alu_d = operand ^ imm; wr_d = 1'b1; end
               C_OP_JMP:  take_d = 1'b1;
               C_OP_JZ:   take_d = z_q;
               C_OP_JNZ:  take_d = !z_q;
               default:   ;
            endcase
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (wr_q) begin
               rf_d[reg_sel] = alu_q;
               z_d           = (alu_q == 8'h00);
            end
            if (opcode == C_OP_HLT) begin
               state_d = S_HALT;
            end else begin
               pc_d    = take_q ? imm : pc_q + 8'd1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rom_addr = pc_q;
   assign pc       = pc_q;
   assign zflag    = z_q;
   assign dbg_data = rf_q[dbg_sel];
   assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
   assign halted   = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ctrl
//  Description : Self-checking bench for cpu_ctrl: instruction table,
//                directed multi-cycle sequences, random programs against an
//                instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [1:0]  dbg_sel;
   logic [7:0]  dbg_data;
   logic [7:0]  pc;
   logic        zflag;
   logic        busy;
   logic        halted;

   logic [15:0] rom [256];

   int n_checks = 0;
   int n_fail   = 0;

   cpu_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data),
      .pc       (pc),
      .zflag    (zflag),
      .busy     (busy),
      .halted   (halted)
   );

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] instr;
      logic [1:0]  sel;
      logic [7:0]  val;
      logic        z;
      logic [7:0]  pc;
      logic        hlt;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic [1:0] s, output logic [7:0] v);
      dbg_sel = s;
      #1;
      v = dbg_data;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges until halted; flags any visit to PC 0x05
   task automatic run_to_halt(input string name, output int n, output bit saw5);
      n    = 0;
      saw5 = 1'b0;
      while (!halted && n < 300) begin
         tick();
         n++;
         if (pc == 8'h05) saw5 = 1'b1;
      end
      if (n >= 300) check({name, "_timeout"}, 0, 1);
   endtask

   // Instruction-level reference model
   logic [7:0] m_r [4];
   logic [7:0] m_pc;
   logic       m_z;
   logic       m_halt;

   task automatic model_step();
      logic [15:0] w;
      logic [7:0]  k, nxt, sum;
      logic [1:0]  s;
      if (m_halt) return;
      w   = rom[m_pc];
      s   = w[9:8];
      k   = w[7:0];
      nxt = m_pc + 8'd1;
      case (w[15:12])
         4'h1: begin m_r[s] = k; m_z = (k == 0); end
         4'h2: begin sum = m_r[s] + k; m_r[s] = sum; m_z = (sum == 0); end
         4'h3: begin m_r[s] = m_r[s] ^ k; m_z = (m_r[s] == 0); end
         4'h4: nxt = k;
         4'h5: if (m_z) nxt = k;
         4'h6: if (!m_z) nxt = k;
         4'hF: begin m_halt = 1'b1; nxt = m_pc; end
         default: ;
      endcase
      m_pc = nxt;
   endtask

   initial begin
      int         n;
      bit         saw5;
      bit         all_busy;
      logic [7:0] v;
      logic [15:0] w;
      logic [3:0] op;

      tbl[0]  = '{8'h00, 16'h1080, 2'd0, 8'h80, 1'b0, 8'h01, 1'b0};
      tbl[1]  = '{8'h01, 16'h2080, 2'd0, 8'h00, 1'b1, 8'h02, 1'b0};
      tbl[2]  = '{8'h02, 16'h7123, 2'd1, 8'h00, 1'b1, 8'h03, 1'b0};
      tbl[3]  = '{8'h03, 16'hE2FF, 2'd2, 8'h00, 1'b1, 8'h04, 1'b0};
      tbl[4]  = '{8'h04, 16'h0000, 2'd0, 8'h00, 1'b1, 8'h05, 1'b0};
      tbl[5]  = '{8'h05, 16'h6009, 2'd0, 8'h00, 1'b1, 8'h06, 1'b0};
      tbl[6]  = '{8'h06, 16'h5008, 2'd0, 8'h00, 1'b1, 8'h08, 1'b0};
      tbl[7]  = '{8'h08, 16'h13AA, 2'd3, 8'hAA, 1'b0, 8'h09, 1'b0};
      tbl[8]  = '{8'h09, 16'h33AA, 2'd3, 8'h00, 1'b1, 8'h0A, 1'b0};
      tbl[9]  = '{8'h0A, 16'h4C0D, 2'd3, 8'h00, 1'b1, 8'h0D, 1'b0};
      tbl[10] = '{8'h0D, 16'h1201, 2'd2, 8'h01, 1'b0, 8'h0E, 1'b0};
      tbl[11] = '{8'h0E, 16'h600B, 2'd2, 8'h01, 1'b0, 8'h0B, 1'b0};
      tbl[12] = '{8'h0B, 16'h3201, 2'd2, 8'h00, 1'b1, 8'h0C, 1'b0};
      tbl[13] = '{8'h0C, 16'hF000, 2'd2, 8'h00, 1'b1, 8'h0C, 1'b1};

      rst_n   = 1'b0;
      start   = 1'b0;
      dbg_sel = 2'd0;
      rom_clear();
      #1;
      // ---- reset state before any clock edge
      check("rst_pc", pc, 8'h00);
      check("rst_rom_addr", rom_addr, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_zflag", zflag, 1'b0);
      read_reg(2'd0, v);
      check("rst_r0", v, 8'h00);
      do_reset();
      repeat (3) tick();
      check("idle_wait_busy", busy, 1'b0);

      // ---- table-driven instruction sequence
      for (int i = 0; i < 14; i++) rom[tbl[i].addr] = tbl[i].instr;
      pulse_start();
      check("tbl_busy_fetch", busy, 1'b1);
      for (int i = 0; i < 14; i++) begin
         repeat (3) tick();
         read_reg(tbl[i].sel, v);
         check($sformatf("tbl%0d_reg", i), v, tbl[i].val);
         check($sformatf("tbl%0d_z", i), zflag, tbl[i].z);
         check($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
         check($sformatf("tbl%0d_halted", i), halted, tbl[i].hlt);
      end

      // ---- program 1: JZ skips address 0x05
      do_reset();
      rom_clear();
      rom[0] = 16'h1005; rom[1] = 16'h2007; rom[2] = 16'h300F; rom[3] = 16'h20FD;
      rom[4] = 16'h5006; rom[5] = 16'h1155; rom[6] = 16'hF000;
      pulse_start();
      run_to_halt("p1", n, saw5);
      check("p1_edges", n, 18);
      check("p1_saw_05", saw5, 1'b0);
      read_reg(2'd0, v); check("p1_r0", v, 8'h00);
      read_reg(2'd1, v); check("p1_r1", v, 8'h00);
      check("p1_z", zflag, 1'b1);
      check("p1_pc", pc, 8'h06);

      // ---- program 2: JNZ not taken
      do_reset();
      rom_clear();
      rom[0] = 16'h1000; rom[1] = 16'h6004; rom[2] = 16'h1177; rom[3] = 16'hF000;
      rom[4] = 16'h2101; rom[5] = 16'hF000;
      pulse_start();
      run_to_halt("p2", n, saw5);
      read_reg(2'd1, v); check("p2_r1", v, 8'h77);
      read_reg(2'd0, v); check("p2_r0", v, 8'h00);
      check("p2_z", zflag, 1'b0);
      check("p2_pc", pc, 8'h03);

      // ---- program 3: ADDI wrap, then restart from HALT
      do_reset();
      rom_clear();
      rom[0] = 16'h11FF; rom[1] = 16'h2102; rom[2] = 16'hF000;
      pulse_start();
      run_to_halt("p3a", n, saw5);
      read_reg(2'd1, v); check("p3_r1_wrap", v, 8'h01);
      check("p3_z", zflag, 1'b0);
      pulse_start();
      check("p3_restart_pc", pc, 8'h00);
      run_to_halt("p3b", n, saw5);
      check("p3_restart_edges", n, 9);
      read_reg(2'd1, v); check("p3_r1_again", v, 8'h01);

      // ---- start held high across a whole run
      do_reset();
      rom_clear();
      rom[0] = 16'h1001; rom[1] = 16'h2001; rom[2] = 16'hF000;
      start = 1'b1;
      tick();
      run_to_halt("hold", n, saw5);
      check("hold_edges", n, 9);
      read_reg(2'd0, v); check("hold_r0", v, 8'h02);
      tick();
      check("hold_restart_busy", busy, 1'b1);
      check("hold_restart_pc", pc, 8'h00);
      start = 1'b0;
      run_to_halt("hold2", n, saw5);
      check("hold2_edges", n, 9);

      // ---- endless JMP/NOP loop through 0xFF, then async reset mid-DECODE
      rom_clear();
      rom[8'h00] = 16'h40FF;
      rom[8'hFF] = 16'h0000;
      pulse_start();
      all_busy = 1'b1;
      for (int i = 0; i < 34; i++) begin
         tick();
         if (!busy) all_busy = 1'b0;
      end
      check("loop_busy", all_busy, 1'b1);
      check("loop_pc_ff", pc, 8'hFF);
      read_reg(2'd0, v); check("loop_r0_kept", v, 8'h02);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_pc", pc, 8'h00);
      check("async_rom_addr", rom_addr, 8'h00);
      check("async_busy", busy, 1'b0);
      check("async_halted", halted, 1'b0);
      check("async_z", zflag, 1'b0);
      read_reg(2'd0, v); check("async_r0", v, 8'h00);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("post_rst_idle_busy", busy, 1'b0);
      check("post_rst_idle_halted", halted, 1'b0);

      // ---- random programs against the reference model
      for (int p = 0; p < 3; p++) begin
         do_reset();
         for (int a = 0; a < 256; a++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
            w = 16'($urandom);
            rom[a] = {op, w[11:0]};
         end
         for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
         m_pc = 8'h00; m_z = 1'b0; m_halt = 1'b0;
         pulse_start();
         for (int k = 0; k < 60; k++) begin
            repeat (3) tick();
            model_step();
            check($sformatf("rnd%0d_%0d_pc", p, k), pc, m_pc);
            check($sformatf("rnd%0d_%0d_z", p, k), zflag, m_z);
            check($sformatf("rnd%0d_%0d_halted", p, k), halted, m_halt);
            for (int r = 0; r < 4; r++) begin
               read_reg(2'(r), v);
               check($sformatf("rnd%0d_%0d_r%0d", p, k, r), v, m_r[r]);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
